attach_user_deadlock_watchdog: RTL and testbench
================================================

ATTACH_USER_DEADLOCK_WATCHDOG -- requirements
Module: attach_user_deadlock_watchdog

Interface
REQ-001 Parameter CNT_W, default 16, width of stall counter and threshold.
REQ-002 Parameter INFO_W, default 4, width of per-stream AXIS block info vector (2 bits per stream, 2 streams).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset values immediately, deassertion synchronous to clock.
REQ-005 enable  input  1  level; 1 = watchdog active, 0 = watchdog disabled.
REQ-006 threshold  input  CNT_W  consecutive blocked cycles required to trip; captured only while disabled.
REQ-007 block  input  1  deadlock-monitor block flag, 1 = stream stall currently reported.
REQ-008 axis_block_info  input  INFO_W  deadlock-monitor per-stream stall info, valid while block=1.
REQ-009 irq_ack  input  1  single-cycle acknowledge of deadlock_irq.
REQ-010 clr_stats  input  1  single-cycle clear of trip_count.
REQ-011 deadlock_irq  output  1  level interrupt, 1 from trip until acknowledged.
REQ-012 captured_info  output  INFO_W  axis_block_info sampled on the tripping cycle.
REQ-013 trip_count  output  8  number of trips, saturating.
REQ-014 stall_cnt  output  CNT_W  current consecutive blocked-cycle count.
REQ-015 state  output  3  FSM state encoding: DISABLED=0, MONITOR=1, SUSPECT=2, TRIPPED=3, RECOVER=4.

Function
REQ-016 All outputs registered; no combinational input-to-output path.
REQ-017 Effective threshold thr_eff = threshold, except threshold=0 treated as 1; thr_eff latched every cycle in DISABLED, held constant in all other states.
REQ-018 enable=0 in any state -> DISABLED next edge; stall_cnt<=0, deadlock_irq<=0; captured_info and trip_count retained.
REQ-019 DISABLED, enable=1 -> MONITOR next edge, using thr_eff latched on that edge.
REQ-020 MONITOR, block=0 -> stay, stall_cnt=0.
REQ-021 MONITOR, block=1 -> stall_cnt<=1; next state TRIPPED if thr_eff=1, else SUSPECT.
REQ-022 SUSPECT, block=0 -> MONITOR, stall_cnt<=0 (any gap resets the run).
REQ-023 SUSPECT, block=1 -> stall_cnt<=stall_cnt+1; if stall_cnt+1 = thr_eff -> TRIPPED.
REQ-024 Trip edge (entry to TRIPPED): deadlock_irq<=1, captured_info<=axis_block_info, trip_count<=trip_count+1 saturating at 255; irq therefore high first on the edge sampling the thr_eff-th consecutive block=1.
REQ-025 TRIPPED: stall_cnt holds trip value; irq_ack=1 -> RECOVER, deadlock_irq<=0; irq_ack ignored in all other states.
REQ-026 RECOVER: stall_cnt<=0; block=0 -> MONITOR; block=1 -> stay (no re-trip on the same stall episode).
REQ-027 clr_stats=1 -> trip_count<=0; same-cycle trip and clr_stats -> trip_count<=1.
REQ-028 enable=0 same cycle as trip condition or irq_ack -> DISABLED wins; no trip, trip_count unchanged.
REQ-029 stall_cnt never wraps; cannot exceed thr_eff by construction.

Reset
REQ-030 reset=0 -> state=DISABLED, deadlock_irq=0, captured_info=0, trip_count=0, stall_cnt=0, thr_eff=1.
REQ-031 Reset mid-operation (any state, including TRIPPED) drops deadlock_irq within the same cycle, no ack required.

Verification
REQ-032 threshold=4, enable=1, block=1 for 4 cycles with info=4'b1101 -> irq=1 after 4th edge, captured_info=4'b1101, trip_count=1, stall_cnt=4.
REQ-033 threshold=4, block pattern 1,1,1,0,1,1,1 -> no trip; stall_cnt sequence 1,2,3,0,1,2,3.
REQ-034 After trip, irq_ack with block still 1 for 10 cycles -> state RECOVER, irq=0, no second trip; block=0 -> MONITOR; new 4-cycle stall -> trip_count=2.
REQ-035 threshold=0 -> single block=1 cycle trips; threshold changed to 8 while enabled -> ignored until enable toggled 0->1.
REQ-036 trip_count preset to 255 via 255 trips, next trip -> stays 255; clr_stats coincident with trip -> 1.
REQ-037 reset=0 asserted asynchronously while TRIPPED -> irq=0 before next edge, all outputs at REQ-030 values; enable=0 coincident with trip condition -> DISABLED, trip_count unchanged.

Source files
------------

// File: rtl/attach_user_deadlock_watchdog.sv
// Deadlock watchdog: counts consecutive cycles the deadlock monitor reports a stall
// and raises a latched interrupt once the run length reaches the effective threshold.
module attach_user_deadlock_watchdog #(
  parameter int CNT_W  = 16,
  parameter int INFO_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              block,
  input  logic [INFO_W-1:0] axis_block_info,
  input  logic              irq_ack,
  input  logic              clr_stats,
  output logic              deadlock_irq,
  output logic [INFO_W-1:0] captured_info,
  output logic [7:0]        trip_count,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    MONITOR  = 3'd1,
    SUSPECT  = 3'd2,
    TRIPPED  = 3'd3,
    RECOVER  = 3'd4
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [CNT_W-1:0]  thr_eff;
  logic [CNT_W-1:0]  thr_nxt;
  logic [CNT_W-1:0]  thr_sel;
  logic [CNT_W-1:0]  stall_nxt;
  logic [CNT_W-1:0]  stall_inc;
  logic              irq_nxt;
  logic [INFO_W-1:0] info_nxt;
  logic [7:0]        count_nxt;
  logic              trip;

  // A zero threshold would never trip, so it behaves as a single-cycle threshold.
  assign thr_sel   = (threshold == '0) ? CNT_W'(1) : threshold;
  assign stall_inc = stall_cnt + CNT_W'(1);
  assign state     = cur_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cur_state <= DISABLED;
    else        cur_state <= nxt_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      thr_eff       <= CNT_W'(1);
      stall_cnt     <= '0;
      deadlock_irq  <= 1'b0;
      captured_info <= '0;
      trip_count    <= '0;
    end else begin
      thr_eff       <= thr_nxt;
      stall_cnt     <= stall_nxt;
      deadlock_irq  <= irq_nxt;
      captured_info <= info_nxt;
      trip_count    <= count_nxt;
    end
  end

  // Disable overrides everything, including a pending trip or acknowledge.
  always_comb begin
    nxt_state = cur_state;
    thr_nxt   = thr_eff;
    stall_nxt = stall_cnt;
    irq_nxt   = deadlock_irq;
    info_nxt  = captured_info;
    count_nxt = trip_count;
    trip      = 1'b0;

    if (!enable) begin
      nxt_state = DISABLED;
      stall_nxt = '0;
      irq_nxt   = 1'b0;
      if (cur_state == DISABLED) thr_nxt = thr_sel;
    end else begin
      case (cur_state)
        DISABLED: begin
          thr_nxt   = thr_sel;
          stall_nxt = '0;
          nxt_state = MONITOR;
        end
        MONITOR: begin
          if (block) begin
            stall_nxt = CNT_W'(1);
            if (thr_eff == CNT_W'(1)) begin
              nxt_state = TRIPPED;
              trip      = 1'b1;
            end else begin
              nxt_state = SUSPECT;
            end
          end else begin
            stall_nxt = '0;
          end
        end
        SUSPECT: begin
          if (!block) begin
            nxt_state = MONITOR;
            stall_nxt = '0;
          end else begin
            stall_nxt = stall_inc;
            if (stall_inc == thr_eff) begin
              nxt_state = TRIPPED;
              trip      = 1'b1;
            end
          end
        end
        TRIPPED: begin
          if (irq_ack) begin
            nxt_state = RECOVER;
            irq_nxt   = 1'b0;
          end
        end
        RECOVER: begin
          // Stay here while the same stall episode persists so it cannot re-trip.
          stall_nxt = '0;
          if (!block) nxt_state = MONITOR;
        end
        default: begin
          nxt_state = DISABLED;
          stall_nxt = '0;
          irq_nxt   = 1'b0;
        end
      endcase
    end

    if (trip) begin
      irq_nxt  = 1'b1;
      info_nxt = axis_block_info;
    end

    if (clr_stats)
      count_nxt = trip ? 8'd1 : 8'd0;
    else if (trip && trip_count != 8'hFF)
      count_nxt = trip_count + 8'd1;
  end

endmodule

// File: tb/tb_attach_user_deadlock_watchdog.sv
// Self-checking bench for the deadlock watchdog: an abstract run-length model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_attach_user_deadlock_watchdog;

  localparam int CNT_W  = 16;
  localparam int INFO_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [CNT_W-1:0]  threshold = '0;
  logic              block = 1'b0;
  logic [INFO_W-1:0] axis_block_info = '0;
  logic              irq_ack = 1'b0;
  logic              clr_stats = 1'b0;
  logic              deadlock_irq;
  logic [INFO_W-1:0] captured_info;
  logic [7:0]        trip_count;
  logic [CNT_W-1:0]  stall_cnt;
  logic [2:0]        state;

  int checks = 0;
  int errors = 0;
  bit compare_on = 1'b0;

  int pat[7]     = '{1, 1, 1, 0, 1, 1, 1};
  int exp_run[7] = '{1, 2, 3, 0, 1, 2, 3};

  attach_user_deadlock_watchdog #(.CNT_W(CNT_W), .INFO_W(INFO_W)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .threshold(threshold),
    .block(block),
    .axis_block_info(axis_block_info),
    .irq_ack(irq_ack),
    .clr_stats(clr_stats),
    .deadlock_irq(deadlock_irq),
    .captured_info(captured_info),
    .trip_count(trip_count),
    .stall_cnt(stall_cnt),
    .state(state)
  );

  always #5 clock = ~clock;

  // Model: tracks whether the watchdog is armed, the length of the current blocked run,
  // and whether an interrupt is pending or the stall episode is being waited out.
  bit         m_active  = 1'b0;
  bit         m_tripped = 1'b0;
  bit         m_recover = 1'b0;
  int         m_run     = 0;
  int         m_thr     = 1;
  int         m_count   = 0;
  logic [3:0] m_info    = '0;

  always @(posedge clock or negedge reset) begin
    bit trip;
    trip = 1'b0;
    if (!reset) begin
      m_active = 0; m_tripped = 0; m_recover = 0;
      m_run = 0; m_thr = 1; m_count = 0; m_info = '0;
    end else begin
      if (!enable) begin
        if (!m_active) m_thr = (threshold == 0) ? 1 : int'(threshold);
        m_active = 0; m_tripped = 0; m_recover = 0; m_run = 0;
      end else if (!m_active) begin
        m_thr = (threshold == 0) ? 1 : int'(threshold);
        m_active = 1; m_run = 0;
      end else if (m_tripped) begin
        if (irq_ack) begin
          m_tripped = 0;
          m_recover = 1;
        end
      end else if (m_recover) begin
        m_run = 0;
        if (!block) m_recover = 0;
      end else if (block) begin
        m_run = m_run + 1;
        if (m_run == m_thr) begin
          trip = 1'b1;
          m_tripped = 1;
          m_info = axis_block_info;
        end
      end else begin
        m_run = 0;
      end
      if (clr_stats) m_count = trip ? 1 : 0;
      else if (trip && m_count < 255) m_count = m_count + 1;
    end
  end

  function automatic int model_state();
    if (!m_active)  return 0;
    if (m_tripped)  return 3;
    if (m_recover)  return 4;
    if (m_run > 0)  return 2;
    return 1;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input bit en, input bit blk, input logic [3:0] info,
                                input bit ack, input bit clr);
    enable          = en;
    block           = blk;
    axis_block_info = info;
    irq_ack         = ack;
    clr_stats       = clr;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (compare_on) begin
      check_output("model_state", int'(state), model_state());
      check_output("model_irq", int'(deadlock_irq), int'(m_tripped));
      check_output("model_info", int'(captured_info), int'(m_info));
      check_output("model_count", int'(trip_count), m_count);
      check_output("model_stall", int'(stall_cnt), m_run);
    end
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst_state", int'(state), 0);
    check_output("rst_irq", int'(deadlock_irq), 0);
    check_output("rst_info", int'(captured_info), 0);
    check_output("rst_count", int'(trip_count), 0);
    check_output("rst_stall", int'(stall_cnt), 0);
    reset = 1'b1;
    compare_on = 1'b1;

    // Basic trip at threshold 4
    threshold = 16'd4;
    apply_stimulus(0, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    check_output("arm_state", int'(state), 1);
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(1, 1, 4'b1101, 0, 0);
      check_output("run_stall", int'(stall_cnt), i);
      check_output("run_irq", int'(deadlock_irq), 0);
    end
    apply_stimulus(1, 1, 4'b1101, 0, 0);
    check_output("trip_irq", int'(deadlock_irq), 1);
    check_output("trip_info", int'(captured_info), 4'b1101);
    check_output("trip_count1", int'(trip_count), 1);
    check_output("trip_stall", int'(stall_cnt), 4);
    check_output("trip_state", int'(state), 3);

    // Acknowledge while the stall persists: no re-trip
    apply_stimulus(1, 1, 4'b0010, 1, 0);
    check_output("ack_state", int'(state), 4);
    check_output("ack_irq", int'(deadlock_irq), 0);
    for (int i = 0; i < 9; i++) apply_stimulus(1, 1, 4'b0010, 0, 0);
    check_output("recover_state", int'(state), 4);
    check_output("recover_count", int'(trip_count), 1);
    check_output("recover_irq", int'(deadlock_irq), 0);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    check_output("rearm_state", int'(state), 1);
    for (int i = 0; i < 4; i++) apply_stimulus(1, 1, 4'b0110, 0, 0);
    check_output("second_count", int'(trip_count), 2);
    check_output("second_info", int'(captured_info), 4'b0110);

    // Interrupted runs never trip
    apply_stimulus(1, 0, 4'b0000, 1, 0);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1, pat[i] != 0, 4'b1111, 0, 0);
      check_output("gap_stall", int'(stall_cnt), exp_run[i]);
      check_output("gap_irq", int'(deadlock_irq), 0);
    end
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    check_output("gap_count", int'(trip_count), 2);

    // Threshold 0 behaves as 1; a change while enabled is ignored until re-enable
    threshold = 16'd0;
    apply_stimulus(0, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 1, 4'b1000, 0, 0);
    check_output("thr0_state", int'(state), 3);
    check_output("thr0_count", int'(trip_count), 3);
    check_output("thr0_info", int'(captured_info), 4'b1000);
    threshold = 16'd8;
    apply_stimulus(1, 0, 4'b0000, 1, 0);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 1, 4'b0100, 0, 0);
    check_output("thr_hold_state", int'(state), 3);
    check_output("thr_hold_count", int'(trip_count), 4);
    apply_stimulus(1, 0, 4'b0000, 1, 0);
    apply_stimulus(0, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 7; i++) apply_stimulus(1, 1, 4'b0011, 0, 0);
    check_output("thr8_pre_irq", int'(deadlock_irq), 0);
    check_output("thr8_pre_stall", int'(stall_cnt), 7);
    apply_stimulus(1, 1, 4'b0011, 0, 0);
    check_output("thr8_irq", int'(deadlock_irq), 1);
    check_output("thr8_count", int'(trip_count), 5);
    check_output("thr8_stall", int'(stall_cnt), 8);

    // Disable coincident with trip condition, then with acknowledge
    apply_stimulus(1, 0, 4'b0000, 1, 0);
    threshold = 16'd2;
    apply_stimulus(0, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 1, 4'b0101, 0, 0);
    apply_stimulus(0, 1, 4'b0101, 0, 0);
    check_output("dis_trip_state", int'(state), 0);
    check_output("dis_trip_irq", int'(deadlock_irq), 0);
    check_output("dis_trip_count", int'(trip_count), 5);
    check_output("dis_trip_info", int'(captured_info), 4'b0011);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 1, 4'b0111, 0, 0);
    apply_stimulus(1, 1, 4'b0111, 0, 0);
    check_output("thr2_count", int'(trip_count), 6);
    apply_stimulus(0, 0, 4'b0000, 1, 0);
    check_output("dis_ack_state", int'(state), 0);
    check_output("dis_ack_irq", int'(deadlock_irq), 0);
    check_output("dis_ack_count", int'(trip_count), 6);

    // Saturation at 255 and clear coincident with a trip
    threshold = 16'd1;
    apply_stimulus(0, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 249; i++) begin
      apply_stimulus(1, 1, 4'b1001, 0, 0);
      apply_stimulus(1, 0, 4'b0000, 1, 0);
      apply_stimulus(1, 0, 4'b0000, 0, 0);
    end
    check_output("sat_count255", int'(trip_count), 255);
    apply_stimulus(1, 1, 4'b1001, 0, 0);
    check_output("sat_hold", int'(trip_count), 255);
    check_output("sat_irq", int'(deadlock_irq), 1);
    apply_stimulus(1, 0, 4'b0000, 1, 0);
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 1, 4'b1010, 0, 1);
    check_output("clr_trip_count", int'(trip_count), 1);
    apply_stimulus(1, 0, 4'b0000, 1, 1);
    check_output("clr_count", int'(trip_count), 0);

    // Asynchronous reset while tripped
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    apply_stimulus(1, 1, 4'b1110, 0, 0);
    check_output("pre_rst_irq", int'(deadlock_irq), 1);
    check_output("pre_rst_count", int'(trip_count), 1);
    #2 reset = 1'b0;
    #1;
    check_output("async_irq", int'(deadlock_irq), 0);
    check_output("async_state", int'(state), 0);
    check_output("async_count", int'(trip_count), 0);
    check_output("async_info", int'(captured_info), 0);
    check_output("async_stall", int'(stall_cnt), 0);
    @(posedge clock);
    #1 reset = 1'b1;
    apply_stimulus(1, 0, 4'b0000, 0, 0);
    check_output("post_rst_state", int'(state), 1);
    apply_stimulus(1, 0, 4'b0000, 0, 0);

    compare_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
